// File: rtl/text_console_writer.sv
// text_console_writer: write side of the text-mode display.
// Turns a stream of 8-bit character codes into writes on the text RAM write
// port. Tracks a cursor, handles CR/LF, wraps at end of line and wraps the
// screen back to row 0. Blanks every newly entered line, and the whole
// screen after reset.
// Optional feature: define TEXT_CONSOLE_BACKSPACE_EN to make 0x08 a
// destructive backspace; otherwise 0x08 is written like any printable code.
module text_console_writer #(
  parameter int         TextCols = 64,
  parameter int         TextRows = 32,
  parameter logic [7:0] BlankChr = 8'h20
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [7:0]                            char_in,
  input  logic                                  char_valid,
  output logic                                  char_ready,
  output logic [$clog2(TextCols*TextRows)-1:0]  TEXT_WA,
  output logic [7:0]                            TEXT_WD,
  output logic                                  TEXT_WE,
  output logic [$clog2(TextCols)-1:0]           cursor_col,
  output logic [$clog2(TextRows)-1:0]           cursor_row
);

  localparam int AW = $clog2(TextCols*TextRows);
  localparam int CW = $clog2(TextCols);
  localparam int RW = $clog2(TextRows);

  localparam logic [CW-1:0] COL_LAST  = CW'(TextCols - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(TextRows - 1);
  localparam logic [AW-1:0] SCRN_LAST = AW'(TextCols*TextRows - 1);
  localparam logic [AW-1:0] LINE_LAST = AW'(TextCols - 1);

  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_CR = 8'h0D;
`ifdef TEXT_CONSOLE_BACKSPACE_EN
  localparam logic [7:0] CHR_BS = 8'h08;
`endif

  typedef enum logic [1:0] {
    S_CLR_SCRN = 2'd0,
    S_IDLE     = 2'd1,
    S_CLR_LINE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;    // cell index for screen clear, column for line clear
  logic [RW-1:0] row_next;   // row entered by LF or auto-wrap
  logic [CW-1:0] col_dec;    // column after a backspace

  assign row_next = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
  assign col_dec  = cursor_col - 1'b1;

  // Linear RAM address of a cell, computed at full address width.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                              input logic [AW-1:0] col);
    return AW'(row) * AW'(TextCols) + col;
  endfunction

  // Control FSM: screen/line clears, character placement and cursor tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLR_SCRN;
      clr_cnt    <= '0;
      char_ready <= 1'b0;
      TEXT_WE    <= 1'b0;
      TEXT_WA    <= '0;
      TEXT_WD    <= BlankChr;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; this default
      // is overridden later in the same block by any branch that writes.
      TEXT_WE <= 1'b0;
      case (state)
        S_CLR_SCRN: begin
          char_ready <= 1'b0;
          TEXT_WE    <= 1'b1;
          TEXT_WA    <= clr_cnt;
          TEXT_WD    <= BlankChr;
          if (clr_cnt == SCRN_LAST) begin
            clr_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          char_ready <= 1'b1;
          if (char_valid && char_ready) begin
            if (char_in == CHR_LF) begin
              cursor_col <= '0;
              cursor_row <= row_next;
              char_ready <= 1'b0;
              state      <= S_CLR_LINE;
            end else if (char_in == CHR_CR) begin
              cursor_col <= '0;
`ifdef TEXT_CONSOLE_BACKSPACE_EN
            end else if (char_in == CHR_BS) begin
              // Column 0 is a no-op: backspace never climbs to the previous row.
              if (cursor_col != '0) begin
                cursor_col <= col_dec;
                TEXT_WE    <= 1'b1;
                TEXT_WA    <= cell_addr(cursor_row, AW'(col_dec));
                TEXT_WD    <= BlankChr;
              end
`endif
            end else begin
              TEXT_WE <= 1'b1;
              TEXT_WA <= cell_addr(cursor_row, AW'(cursor_col));
              TEXT_WD <= char_in;
              if (cursor_col == COL_LAST) begin
                // Auto-wrap behaves like LF once this character is written.
                cursor_col <= '0;
                cursor_row <= row_next;
                char_ready <= 1'b0;
                state      <= S_CLR_LINE;
              end else begin
                cursor_col <= cursor_col + 1'b1;
              end
            end
          end
        end

        S_CLR_LINE: begin
          // char_ready stays low through the last clear and rises one cycle later in S_IDLE.
          char_ready <= 1'b0;
          TEXT_WE    <= 1'b1;
          TEXT_WA    <= cell_addr(cursor_row, clr_cnt);
          TEXT_WD    <= BlankChr;
          if (clr_cnt == LINE_LAST) begin
            clr_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        default: begin
          state      <= S_CLR_SCRN;
          clr_cnt    <= '0;
          char_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (64x32, blank 0x20).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [10:0] TEXT_WA;
  logic [7:0]  TEXT_WD;
  logic        TEXT_WE;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .TEXT_WA    (TEXT_WA),
    .TEXT_WD    (TEXT_WD),
    .TEXT_WE    (TEXT_WE),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: char_ready=%b want 1", name, char_ready);
    end
  endtask

  // Leaves the bench 1 unit after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    wait_ready("send");
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  // Called right after reset has been released following a reset edge.
  task automatic expect_screen_clear(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 2048; i++) begin
      tick();
      if (TEXT_WE !== 1'b1 || TEXT_WA !== 11'(i) || TEXT_WD !== 8'h20 || char_ready !== 1'b0) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_scrn_clear: %0d bad cycles, first at %0d, got we=%b wa=%0d wd=%h, want 0 bad",
               name, bad, first, TEXT_WE, TEXT_WA, TEXT_WD);
    end
    tick();
    checks++;
    if ({char_ready, TEXT_WE, cursor_col, cursor_row} !== {1'b1, 1'b0, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s_after_clear: ready=%b we=%b cursor=(%0d,%0d) want ready=1 we=0 (0,0)",
               name, char_ready, TEXT_WE, cursor_col, cursor_row);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({char_ready, TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row} !==
        {1'b0, 1'b0, 11'd0, 8'h20, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b we=%b wa=%0d wd=%h cursor=(%0d,%0d) want 0 0 0 20 (0,0)",
               char_ready, TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row);
    end
    reset = 1'b0;
    expect_screen_clear("reset");
  endtask

  task automatic test_single_char();
    send_char(8'h41);
    checks++;
    if ({TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row} !== {1'b1, 11'd0, 8'h41, 6'd1, 5'd0}) begin
      errors++;
      $display("FAIL char_A: we=%b wa=%0d wd=%h cursor=(%0d,%0d) want 1 0 41 (1,0)",
               TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row);
    end
    tick();
    checks++;
    if (TEXT_WE !== 1'b0) begin
      errors++;
      $display("FAIL char_A_single_write: we=%b want 0", TEXT_WE);
    end
    send_char(8'h0D);
    checks++;
    if ({TEXT_WE, cursor_col, cursor_row} !== {1'b0, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL cr_row0: we=%b cursor=(%0d,%0d) want 0 (0,0)", TEXT_WE, cursor_col, cursor_row);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int first = -1;
    wait_ready("b2b");
    char_in    = 8'h42;
    char_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k == 63) char_valid = 1'b0;
      if (TEXT_WE !== 1'b1 || TEXT_WA !== 11'(k) || TEXT_WD !== 8'h42 ||
          char_ready !== (k < 63) ||
          cursor_col !== ((k < 63) ? 6'(k + 1) : 6'd0) ||
          cursor_row !== ((k < 63) ? 5'd0 : 5'd1)) begin
        if (bad == 0) first = k;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_writes: %0d bad cycles, first at %0d, want 0 bad", bad, first);
    end
    bad = 0;
    first = -1;
    for (int j = 0; j < 64; j++) begin
      tick();
      if (TEXT_WE !== 1'b1 || TEXT_WA !== 11'(64 + j) || TEXT_WD !== 8'h20 || char_ready !== 1'b0 ||
          cursor_col !== 6'd0 || cursor_row !== 5'd1) begin
        if (bad == 0) first = j;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_line_clear: %0d bad cycles, first at %0d, want 0 bad", bad, first);
    end
    tick();
    checks++;
    if ({char_ready, TEXT_WE} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_ready_return: ready=%b we=%b want 1 0", char_ready, TEXT_WE);
    end
  endtask

  task automatic test_screen_wrap();
    int bad = 0;
    for (int i = 0; i < 30; i++) send_char(8'h0A);
    for (int i = 0; i < 7; i++) send_char(8'h78);
    checks++;
    if ({cursor_col, cursor_row} !== {6'd7, 5'd31}) begin
      errors++;
      $display("FAIL reach_7_31: cursor=(%0d,%0d) want (7,31)", cursor_col, cursor_row);
    end
    send_char(8'h0A);
    checks++;
    if ({TEXT_WE, cursor_col, cursor_row} !== {1'b0, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL lf_last_row: we=%b cursor=(%0d,%0d) want 0 (0,0)", TEXT_WE, cursor_col, cursor_row);
    end
    for (int j = 0; j < 64; j++) begin
      tick();
      if (TEXT_WE !== 1'b1 || TEXT_WA !== 11'(j) || TEXT_WD !== 8'h20 || char_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL row0_clear: %0d bad cycles want 0", bad);
    end
    for (int i = 0; i < 5; i++) send_char(8'h79);
    checks++;
    if ({cursor_col, cursor_row} !== {6'd5, 5'd0}) begin
      errors++;
      $display("FAIL reach_5_0: cursor=(%0d,%0d) want (5,0)", cursor_col, cursor_row);
    end
    send_char(8'h0D);
    checks++;
    if ({TEXT_WE, cursor_col, cursor_row} !== {1'b0, 6'd0, 5'd0}) begin
      errors++;
      $display("FAIL cr_5_0: we=%b cursor=(%0d,%0d) want 0 (0,0)", TEXT_WE, cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace();
    send_char(8'h0A);
    send_char(8'h0A);
`ifdef TEXT_CONSOLE_BACKSPACE_EN
    for (int i = 0; i < 5; i++) send_char(8'h7A);
    send_char(8'h08);
    checks++;
    if ({TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row} !== {1'b1, 11'd132, 8'h20, 6'd4, 5'd2}) begin
      errors++;
      $display("FAIL bs_5_2: we=%b wa=%0d wd=%h cursor=(%0d,%0d) want 1 132 20 (4,2)",
               TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row);
    end
    send_char(8'h0D);
    send_char(8'h08);
    checks++;
    if ({TEXT_WE, cursor_col, cursor_row} !== {1'b0, 6'd0, 5'd2}) begin
      errors++;
      $display("FAIL bs_col0: we=%b cursor=(%0d,%0d) want 0 (0,2)", TEXT_WE, cursor_col, cursor_row);
    end
`else
    send_char(8'h08);
    checks++;
    if ({TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row} !== {1'b1, 11'd128, 8'h08, 6'd1, 5'd2}) begin
      errors++;
      $display("FAIL bs_printable: we=%b wa=%0d wd=%h cursor=(%0d,%0d) want 1 128 08 (1,2)",
               TEXT_WE, TEXT_WA, TEXT_WD, cursor_col, cursor_row);
    end
`endif
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("mid_init");
    char_in    = 8'h42;
    char_valid = 1'b1;
    repeat (64) tick();
    char_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (TEXT_WE !== 1'b1 || TEXT_WA !== 11'(64 + j)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_first_clears: %0d bad cycles want 0", bad);
    end
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++;
      if ({TEXT_WE, char_ready, cursor_col, cursor_row} !== {1'b0, 1'b0, 6'd0, 5'd0}) begin
        errors++;
        $display("FAIL mid_in_reset: we=%b ready=%b cursor=(%0d,%0d) want 0 0 (0,0)",
                 TEXT_WE, char_ready, cursor_col, cursor_row);
      end
    end
    reset = 1'b0;
    expect_screen_clear("mid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_char();
    test_back_to_back();
    test_screen_wrap();
    test_backspace();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
